// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_arbiter
//  Description : Shares one downstream memory-port handshake between the
//                core's instruction-fetch request and its data request.
//                Data has priority; a fetch is forced after STARVE_MAX data
//                grants made while it waits. Optional WAIT timeout is enabled
//                by defining MEM_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_vld,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_head,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_vld,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_src,
    output logic [3:0]  m_head,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvld,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam int                    c_STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);
    localparam logic [3:0]            c_FETCH_HEAD = 4'b0111;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_src;
    logic [3:0]            r_head;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_i_rdata;
    logic [31:0]           r_d_rdata;
    logic [c_STARVE_W-1:0] r_starve;

    logic                  w_i_elig;
    logic                  w_d_elig;
    logic                  w_grant;
    logic                  w_grant_src;
    logic                  w_timeout;
    logic                  w_wait_expired;
    logic                  w_capture;
    logic [31:0]           w_cap_data;

    // A requester whose response pulse is showing is ignored so the core can
    // replace its request; the pulse is decoded from RESP, so this only
    // matters if the pulse ever overlaps an arbitration cycle.
    assign w_i_elig = i_req & ~i_vld;
    assign w_d_elig = d_req & ~d_vld;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration decision and timeout detection
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_src = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_i_elig || w_d_elig) begin
                    w_grant     = 1'b1;
                    // Data wins unless the waiting fetch has been starved out
                    w_grant_src = w_d_elig && !(w_i_elig && (r_starve == c_STARVE_MAX));
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (m_gnt) begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (m_rvld) begin
                    w_state_nxt = c_RESP;
                end else if (w_wait_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // A timed-out request returns zero data to its requester
    assign w_capture  = (r_state == c_WAIT) && (w_state_nxt == c_RESP);
    assign w_cap_data = w_timeout ? 32'h0 : m_rdata;

    // Latch the winner's payload at grant and route response data back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src     <= 1'b0;
            r_head    <= 4'h0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_i_rdata <= 32'h0;
            r_d_rdata <= 32'h0;
        end else begin
            if (w_grant) begin
                r_src   <= w_grant_src;
                r_head  <= w_grant_src ? d_head  : c_FETCH_HEAD;
                r_addr  <= w_grant_src ? d_addr  : i_addr;
                r_wdata <= w_grant_src ? d_wdata : 32'h0;
            end
            if (w_capture) begin
                if (r_src) begin
                    r_d_rdata <= w_cap_data;
                end else begin
                    r_i_rdata <= w_cap_data;
                end
            end
        end
    end

    // Count data grants that bypass a waiting fetch; any fetch grant clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (!w_grant_src) begin
                r_starve <= '0;
            end else if (i_req && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_err;

    // WAIT-cycle counter: zero on entry, advancing once per WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Error flag covers exactly the RESP cycle that follows a timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign w_wait_expired = (r_wait_cnt == c_WAIT_LAST);
    assign err            = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_wait_expired   = 1'b0;
    assign err              = 1'b0;
`endif

    assign m_req   = (r_state == c_ISSUE);
    assign m_src   = r_src;
    assign m_head  = r_head;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_vld   = (r_state == c_RESP) && !r_src;
    assign d_vld   = (r_state == c_RESP) && r_src;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_mem_arbiter
//  Description : Self-checking bench for core_mem_arbiter. Acts as both the
//                core and the downstream memory; a transaction-level model
//                predicts the grant order, payloads and returned data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_vld;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_head;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_vld;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_src;
    logic [3:0]  m_head;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvld;
    logic [31:0] m_rdata;
    logic        busy;
    logic        err;

    core_mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_vld   (i_vld),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_head  (d_head),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_vld   (d_vld),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_src   (m_src),
        .m_head  (m_head),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_gnt   (m_gnt),
        .m_rvld  (m_rvld),
        .m_rdata (m_rdata),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          starve_m = 0;
    logic [31:0] last_i   = 32'h0;
    logic [31:0] last_d   = 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_m_req"},   m_req,   0);
        chk({p, "_m_src"},   m_src,   0);
        chk({p, "_m_head"},  m_head,  0);
        chk({p, "_m_addr"},  m_addr,  0);
        chk({p, "_m_wdata"}, m_wdata, 0);
        chk({p, "_i_vld"},   i_vld,   0);
        chk({p, "_d_vld"},   d_vld,   0);
        chk({p, "_i_rdata"}, i_rdata, 0);
        chk({p, "_d_rdata"}, d_rdata, 0);
        chk({p, "_busy"},    busy,    0);
        chk({p, "_err"},     err,     0);
    endtask

    // Reference arbitration: data first, fetch when starved or data absent
    task automatic model_grant(input bit ireq, input bit dreq, output bit src);
        src = !(ireq && ((starve_m == STARVE_MAX) || !dreq));
        if (!src)
            starve_m = 0;
        else if (ireq && starve_m < STARVE_MAX)
            starve_m = starve_m + 1;
    endtask

    // Memory side: wait for a request, apply backpressure, then respond
    task automatic serve(input int gnt_dly, input int rsp_dly, input logic [31:0] rdata,
                         input bit poke, output logic src, output logic [3:0] head,
                         output logic [31:0] addr, output logic [31:0] wdata);
        int n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", m_req, 1);
        src   = m_src;
        head  = m_head;
        addr  = m_addr;
        wdata = m_wdata;
        for (int k = 0; k < gnt_dly; k++) begin
            m_rvld  = poke && (k == gnt_dly / 2);
            m_rdata = 32'hDEAD_0000;
            step();
            m_rvld = 1'b0;
            chk("bp_req",  m_req,  1);
            chk("bp_addr", m_addr, addr);
            chk("bp_head", m_head, head);
            chk("bp_busy", busy,   1);
        end
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        chk("wait_req", m_req, 0);
        for (int k = 0; k < rsp_dly; k++) begin
            step();
            chk("wait_novld", {30'h0, i_vld, d_vld}, 0);
        end
        m_rvld  = 1'b1;
        m_rdata = rdata;
        step();
        m_rvld = 1'b0;
    endtask

    task automatic check_resp(input bit src_exp, input logic [31:0] rdata);
        if (src_exp) last_d = rdata; else last_i = rdata;
        chk("i_vld",   i_vld,   !src_exp);
        chk("d_vld",   d_vld,   src_exp);
        chk("i_rdata", i_rdata, last_i);
        chk("d_rdata", d_rdata, last_d);
    endtask

    task automatic finish_resp();
        step();
        chk("vld_once", {30'h0, i_vld, d_vld}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        src;
        logic [3:0]  head;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          exp_src;
        bit          pi, pd;
        logic [31:0] pi_addr, pd_addr, pd_wdata;
        logic [3:0]  pd_head;
        bit          conflict_tab [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_head = 0; d_addr = 0; d_wdata = 0;
        m_gnt = 0; m_rvld = 0; m_rdata = 0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Fetch alone: granted on the first edge, fetch header, data returned
        i_req = 1'b1; i_addr = 32'h100;
        step();
        chk("fetch_grant_1cyc", m_req, 1);
        model_grant(1, 0, exp_src);
        serve(0, 0, 32'h8C22_0004, 0, src, head, addr, wdata);
        chk("fetch_src",   src,   exp_src);
        chk("fetch_head",  head,  4'b0111);
        chk("fetch_addr",  addr,  32'h100);
        chk("fetch_wdata", wdata, 0);
        check_resp(0, 32'h8C22_0004);
        chk("fetch_i_rdata_lit", i_rdata, 32'h8C22_0004);
        i_req = 1'b0;
        finish_resp();
        chk("fetch_idle", busy, 0);

        // Store: payload forwarded, write acknowledged on d_vld only
        d_req = 1'b1; d_head = 4'b1110; d_addr = 32'h40; d_wdata = 32'h55;
        model_grant(0, 1, exp_src);
        serve(0, 1, 32'h1234_5678, 0, src, head, addr, wdata);
        chk("store_src",   src,   exp_src);
        chk("store_head",  head,  4'b1110);
        chk("store_addr",  addr,  32'h40);
        chk("store_wdata", wdata, 32'h55);
        check_resp(1, 32'h1234_5678);
        d_req = 1'b0;
        finish_resp();

        // Conflict: both held; four data grants, then the fetch is forced
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_head = 4'b0110; d_addr = 32'h200; d_wdata = 32'h0;
        for (int g = 0; g < 10; g++) begin
            rd = 32'h1000 + 32'(g);
            model_grant(1, 1, exp_src);
            serve(0, 0, rd, 0, src, head, addr, wdata);
            chk($sformatf("conf_src_model%0d", g), src, exp_src);
            chk($sformatf("conf_src_tab%0d", g),   src, conflict_tab[g]);
            chk($sformatf("conf_addr%0d", g),      addr, exp_src ? 32'h200 : 32'h300);
            check_resp(exp_src, rd);
            if (g == 9) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            finish_resp();
        end

        // Backpressure: 10 cycles without m_gnt and a stray m_rvld in ISSUE
        d_req = 1'b1; d_head = 4'b0010; d_addr = 32'h80; d_wdata = 32'h0;
        model_grant(0, 1, exp_src);
        serve(10, 2, 32'hCAFE_F00D, 1, src, head, addr, wdata);
        chk("bp_src",     src,  exp_src);
        chk("bp_addr_ok", addr, 32'h80);
        check_resp(1, 32'hCAFE_F00D);
        d_req = 1'b0;
        finish_resp();

        // Reset during WAIT, then a late response in IDLE
        i_req = 1'b1; i_addr = 32'h500;
        step();
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        chk("rst_in_wait", {31'h0, busy & ~m_req}, 1);
        i_req = 1'b0;
        rst   = 1'b1;
        #1;
        chk_zero("rst_async");
        step();
        rst = 1'b0;
        starve_m = 0; last_i = 0; last_d = 0;
        m_rvld = 1'b1; m_rdata = 32'h0BAD_0BAD;
        step();
        m_rvld = 1'b0;
        chk_zero("late_rvld");
        step();
        chk_zero("late_rvld2");

        // Randomised traffic against the transaction model
        pi = 1; pi_addr = $urandom;
        pd = $urandom_range(0, 1); pd_head = 4'($urandom); pd_addr = $urandom; pd_wdata = $urandom;
        for (int t = 0; t < 40; t++) begin
            i_req = pi; i_addr = pi_addr;
            d_req = pd; d_head = pd_head; d_addr = pd_addr; d_wdata = pd_wdata;
            rd = $urandom;
            model_grant(pi, pd, exp_src);
            serve($urandom_range(0, 3), $urandom_range(0, 3), rd, 1'($urandom_range(0, 1)),
                  src, head, addr, wdata);
            chk("rnd_src",   src,   exp_src);
            chk("rnd_head",  head,  exp_src ? pd_head  : 4'b0111);
            chk("rnd_addr",  addr,  exp_src ? pd_addr  : pi_addr);
            chk("rnd_wdata", wdata, exp_src ? pd_wdata : 32'h0);
            check_resp(exp_src, rd);
            if (exp_src) begin
                pd = $urandom_range(0, 1); pd_head = 4'($urandom); pd_addr = $urandom; pd_wdata = $urandom;
            end else begin
                pi = $urandom_range(0, 1); pi_addr = $urandom;
            end
            if (!pi && !pd) begin
                pi = 1; pi_addr = $urandom;
            end
            i_req = pi; i_addr = pi_addr;
            d_req = pd; d_head = pd_head; d_addr = pd_addr; d_wdata = pd_wdata;
            if (t == 39) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            finish_resp();
        end
        step();
        chk("rnd_idle", busy, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: no response ever; err and zero data after TIMEOUT WAIT cycles
        d_req = 1'b1; d_head = 4'b0110; d_addr = 32'h900; d_wdata = 32'h0;
        step();
        chk("to_issue", m_req, 1);
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            chk("to_wait_err",  err,   0);
            chk("to_wait_busy", busy,  1);
            chk("to_wait_dvld", d_vld, 0);
        end
        step();
        chk("to_err",     err,     1);
        chk("to_d_vld",   d_vld,   1);
        chk("to_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        step();
        chk("to_err_clr", err,   0);
        chk("to_idle",    busy,  0);
        chk("to_vld_clr", d_vld, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
